// File: rtl/sfp_pkg.sv
// Shared definitions for the multi-column special-function processor:
// accumulator saturation limits, control FSM encoding, and the width of
// the accumulate-event counter.
package sfp_pkg;

  localparam int unsigned ACC_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2
  } sfp_state_t;

  // Largest value representable in a signed w-bit accumulator.
  function automatic longint psum_max(input int unsigned w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  // Smallest value representable in a signed w-bit accumulator.
  function automatic longint psum_min(input int unsigned w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/sfp_lane.sv
// One column of the special-function processor: saturating signed
// accumulator, sticky saturation flag, and registered (optionally ReLU'd)
// output.
//
// Ports:
//   clk, reset : clock, async active-high reset
//   in         : signed bw-bit partial value for this column
//   acc_ev     : accumulate event this cycle
//   clr        : synchronous clear of psum and sat (out is kept)
//   rd         : read; out captures the current psum
//   restart    : read that also restarts accumulation (clear-on-read)
//   relu       : clamp negative psum to 0 on read
//   out        : registered result
//   sat        : sticky saturation flag
module sfp_lane
  import sfp_pkg::*;
#(
  parameter int unsigned bw      = 4,
  parameter int unsigned psum_bw = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [bw-1:0]      in,
  input  logic               acc_ev,
  input  logic               clr,
  input  logic               rd,
  input  logic               restart,
  input  logic               relu,
  output logic [psum_bw-1:0] out,
  output logic               sat
);

  localparam logic [psum_bw-1:0] PSUM_MAX = psum_bw'(psum_max(psum_bw));
  localparam logic [psum_bw-1:0] PSUM_MIN = psum_bw'(psum_min(psum_bw));

  logic [psum_bw-1:0] psum;
  logic [psum_bw-1:0] in_ext;
  logic [psum_bw:0]   sum;
  logic [psum_bw-1:0] sum_sat;
  logic               ovf;
  logic [psum_bw-1:0] rd_val;

  assign in_ext = {{(psum_bw - bw){in[bw-1]}}, in};

  // One guard bit: overflow shows up as the top two bits disagreeing,
  // and the guard bit then gives the true sign of the result.
  assign sum     = {psum[psum_bw-1], psum} + {in_ext[psum_bw-1], in_ext};
  assign ovf     = sum[psum_bw] ^ sum[psum_bw-1];
  assign sum_sat = ovf ? (sum[psum_bw] ? PSUM_MIN : PSUM_MAX) : sum[psum_bw-1:0];

  assign rd_val  = (relu && psum[psum_bw-1]) ? '0 : psum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      psum <= '0;
      out  <= '0;
      sat  <= 1'b0;
    end else if (clr) begin
      psum <= '0;
      sat  <= 1'b0;
    end else begin
      if (rd) out <= rd_val;
      // A same-cycle accumulate on a restarting read seeds the new sum.
      if (restart) begin
        psum <= acc_ev ? in_ext : '0;
        sat  <= 1'b0;
      end else if (acc_ev) begin
        psum <= sum_sat;
        if (ovf) sat <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sfp_array.sv
// Multi-column special-function processor. Accumulates one signed row per
// accumulate event into col saturating lanes and emits all lanes on a read.
//
// Ports:
//   clk, reset : clock, async active-high reset
//   in         : packed inputs, lane c = in[c*bw +: bw]
//   in_valid   : in carries valid data
//   acc        : accumulate enable (qualified by in_valid)
//   relu       : ReLU on read
//   rd         : read command pulse
//   clr        : synchronous clear (wins over rd and acc)
//   out        : packed results, lane c = out[c*psum_bw +: psum_bw]
//   out_valid  : one-cycle pulse when out updates
//   sat        : per-lane sticky saturation flags
//   acc_cnt    : accumulate events since last clear, saturating
module sfp_array
  import sfp_pkg::*;
#(
  parameter int unsigned bw        = 4,
  parameter int unsigned psum_bw   = 16,
  parameter int unsigned col       = 8,
  parameter bit          clr_on_rd = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [col*bw-1:0]      in,
  input  logic                   in_valid,
  input  logic                   acc,
  input  logic                   relu,
  input  logic                   rd,
  input  logic                   clr,
  output logic [col*psum_bw-1:0] out,
  output logic                   out_valid,
  output logic [col-1:0]         sat,
  output logic [ACC_CNT_W-1:0]   acc_cnt
);

  sfp_state_t state, state_nxt;
  logic       acc_ev;
  logic       rd_ev;
  logic       restart;

  assign acc_ev  = acc & in_valid & ~clr;
  assign rd_ev   = rd & ~clr;
  assign restart = rd_ev & clr_on_rd;

  for (genvar c = 0; c < col; c++) begin : g_lane
    sfp_lane #(
      .bw      (bw),
      .psum_bw (psum_bw)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .in      (in[c*bw +: bw]),
      .acc_ev  (acc_ev),
      .clr     (clr),
      .rd      (rd_ev),
      .restart (restart),
      .relu    (relu),
      .out     (out[c*psum_bw +: psum_bw]),
      .sat     (sat[c])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_cnt <= '0;
    end else if (clr) begin
      acc_cnt <= '0;
    end else if (restart) begin
      acc_cnt <= acc_ev ? ACC_CNT_W'(1) : '0;
    end else if (acc_ev && (acc_cnt != '1)) begin
      acc_cnt <= acc_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // In EMIT, a non-zero acc_cnt means the read cycle carried an accumulate
  // that now belongs to the restarted sum.
  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = IDLE;
    end else if (rd) begin
      state_nxt = EMIT;
    end else begin
      case (state)
        IDLE:    if (acc_ev) state_nxt = ACCUM;
        ACCUM:   state_nxt = ACCUM;
        EMIT:    state_nxt = (acc_ev || !clr_on_rd || (acc_cnt != '0)) ? ACCUM : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign out_valid = (state == EMIT);

endmodule

// File: tb/tb_sfp_array.sv
// Directed self-checking bench for sfp_array: a default instance
// (16-bit psum, 8 lanes, clear-on-read) and a narrow instance
// (8-bit psum, 2 lanes, psum retained on read) for saturation.
module tb_sfp_array;

  logic        clk;
  logic        reset;

  logic [31:0]  in;
  logic         in_valid, acc, relu, rd, clr;
  logic [127:0] out;
  logic         out_valid;
  logic [7:0]   sat;
  logic [15:0]  acc_cnt;

  logic [7:0]   in8;
  logic         in_valid8, acc8, relu8, rd8, clr8;
  logic [15:0]  out8;
  logic         out_valid8;
  logic [1:0]   sat8;
  logic [15:0]  acc_cnt8;

  int unsigned n_cmp;
  int unsigned n_err;

  sfp_array u_dut (
    .clk       (clk),
    .reset     (reset),
    .in        (in),
    .in_valid  (in_valid),
    .acc       (acc),
    .relu      (relu),
    .rd        (rd),
    .clr       (clr),
    .out       (out),
    .out_valid (out_valid),
    .sat       (sat),
    .acc_cnt   (acc_cnt)
  );

  sfp_array #(
    .bw        (4),
    .psum_bw   (8),
    .col       (2),
    .clr_on_rd (1'b0)
  ) u_dut8 (
    .clk       (clk),
    .reset     (reset),
    .in        (in8),
    .in_valid  (in_valid8),
    .acc       (acc8),
    .relu      (relu8),
    .rd        (rd8),
    .clr       (clr8),
    .out       (out8),
    .out_valid (out_valid8),
    .sat       (sat8),
    .acc_cnt   (acc_cnt8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_lanes(input string tag, input logic [15:0] exp);
    for (int c = 0; c < 8; c++)
      check_val($sformatf("%s_lane%0d", tag, c), 64'(out[c*16 +: 16]), 64'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    in = '0; in_valid = 1'b0; acc = 1'b0; relu = 1'b0; rd = 1'b0; clr = 1'b0;
    in8 = '0; in_valid8 = 1'b0; acc8 = 1'b0; relu8 = 1'b0; rd8 = 1'b0; clr8 = 1'b0;
    tick(); tick();
    check_lanes("rst_out", 16'h0000);
    check_val("rst_out_valid", 64'(out_valid), 64'h0);
    check_val("rst_sat", 64'(sat), 64'h0);
    check_val("rst_acc_cnt", 64'(acc_cnt), 64'h0);
    check_val("rst_out8", 64'(out8), 64'h0);
    reset = 1'b0;
    tick();

    // All lanes accumulate 3 for 10 cycles, then read with ReLU.
    in = {8{4'd3}}; in_valid = 1'b1; acc = 1'b1;
    repeat (10) tick();
    acc = 1'b0;
    check_val("t1_cnt_before", 64'(acc_cnt), 64'd10);
    check_val("t1_no_valid", 64'(out_valid), 64'h0);
    rd = 1'b1; relu = 1'b1;
    tick();
    rd = 1'b0;
    check_val("t1_valid", 64'(out_valid), 64'h1);
    check_lanes("t1_out", 16'd30);
    check_val("t1_cnt_after", 64'(acc_cnt), 64'd0);
    tick();
    check_val("t1_valid_drop", 64'(out_valid), 64'h0);
    check_val("t1_out_hold", 64'(out[15:0]), 64'd30);

    // Lane 0 negative, other lanes +1: ReLU then passthrough.
    in = {{7{4'd1}}, 4'h8}; acc = 1'b1;
    repeat (10) tick();
    acc = 1'b0; rd = 1'b1; relu = 1'b1;
    tick();
    rd = 1'b0;
    check_val("t2_relu_lane0", 64'(out[15:0]), 64'h0);
    check_val("t2_relu_lane1", 64'(out[31:16]), 64'd10);
    acc = 1'b1;
    repeat (10) tick();
    acc = 1'b0; rd = 1'b1; relu = 1'b0;
    tick();
    rd = 1'b0;
    check_val("t2_pass_lane0", 64'(out[15:0]), 64'hFFB0);
    check_val("t2_pass_lane7", 64'(out[127:112]), 64'd10);
    check_val("t2_sat", 64'(sat), 64'h0);

    // Clear-on-read with a same-cycle accumulate, then back-to-back reads.
    in = {8{4'd3}}; acc = 1'b1;
    repeat (10) tick();
    in = {8{4'd5}}; rd = 1'b1;
    tick();
    acc = 1'b0;
    check_lanes("t4_first", 16'd30);
    check_val("t4_valid_a", 64'(out_valid), 64'h1);
    check_val("t4_cnt", 64'(acc_cnt), 64'd1);
    tick();
    check_lanes("t4_second", 16'd5);
    check_val("t4_valid_b", 64'(out_valid), 64'h1);
    check_val("t4_cnt_b", 64'(acc_cnt), 64'd0);
    tick();
    rd = 1'b0;
    check_val("t4_third", 64'(out[15:0]), 64'd0);
    check_val("t4_valid_c", 64'(out_valid), 64'h1);
    tick();
    check_val("t4_valid_end", 64'(out_valid), 64'h0);

    // clr beats rd and acc in the same cycle.
    in = {8{4'd2}}; acc = 1'b1;
    repeat (3) tick();
    acc = 1'b0; rd = 1'b1;
    tick();
    rd = 1'b0;
    check_lanes("t5_pre", 16'd6);
    acc = 1'b1;
    repeat (3) tick();
    check_val("t5_cnt_pre", 64'(acc_cnt), 64'd3);
    clr = 1'b1; rd = 1'b1;
    tick();
    clr = 1'b0; rd = 1'b0; acc = 1'b0;
    check_val("t5_no_valid", 64'(out_valid), 64'h0);
    check_val("t5_cnt", 64'(acc_cnt), 64'd0);
    check_val("t5_sat", 64'(sat), 64'h0);
    check_lanes("t5_out_kept", 16'd6);
    tick();
    check_val("t5_still_no_valid", 64'(out_valid), 64'h0);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    check_lanes("t5_psum_zero", 16'd0);
    check_val("t5_valid", 64'(out_valid), 64'h1);
    tick();

    // Narrow instance: positive then negative saturation, sticky flag.
    in8 = {4'd0, 4'd7}; in_valid8 = 1'b1; acc8 = 1'b1;
    repeat (20) tick();
    acc8 = 1'b0;
    check_val("t3_sat_pos", 64'(sat8), 64'h1);
    check_val("t3_cnt20", 64'(acc_cnt8), 64'd20);
    rd8 = 1'b1;
    tick();
    rd8 = 1'b0;
    check_val("t3_out_max", 64'(out8[7:0]), 64'h7F);
    check_val("t3_out_lane1", 64'(out8[15:8]), 64'h0);
    check_val("t3_valid8", 64'(out_valid8), 64'h1);
    check_val("t3_sat_kept", 64'(sat8), 64'h1);
    in8 = {4'd0, 4'h8}; acc8 = 1'b1;
    repeat (40) tick();
    acc8 = 1'b0; rd8 = 1'b1;
    tick();
    rd8 = 1'b0;
    check_val("t3_out_min", 64'(out8[7:0]), 64'h80);
    check_val("t3_sat_neg", 64'(sat8), 64'h1);
    check_val("t3_cnt60", 64'(acc_cnt8), 64'd60);
    clr8 = 1'b1;
    tick();
    clr8 = 1'b0;
    check_val("t3_sat_clr", 64'(sat8), 64'h0);
    check_val("t3_cnt_clr", 64'(acc_cnt8), 64'd0);
    in8 = {4'd0, 4'd7}; acc8 = 1'b1;
    repeat (20) tick();
    acc8 = 1'b0;
    check_val("t3_sat_again", 64'(sat8), 64'h1);

    // Async reset between edges while out_valid is high.
    in = {8{4'd4}}; acc = 1'b1;
    repeat (3) tick();
    acc = 1'b0; rd = 1'b1;
    tick();
    rd = 1'b0;
    check_val("t6_valid_pre", 64'(out_valid), 64'h1);
    check_val("t6_out_pre", 64'(out[15:0]), 64'd12);
    #2 reset = 1'b1;
    #1;
    check_lanes("t6_out", 16'd0);
    check_val("t6_valid", 64'(out_valid), 64'h0);
    check_val("t6_cnt", 64'(acc_cnt), 64'd0);
    check_val("t6_sat8", 64'(sat8), 64'h0);
    check_val("t6_out8", 64'(out8), 64'h0);
    check_val("t6_cnt8", 64'(acc_cnt8), 64'd0);
    reset = 1'b0;
    in = {8{4'd1}}; acc = 1'b1;
    repeat (2) tick();
    acc = 1'b0;
    check_val("t6_cnt_restart", 64'(acc_cnt), 64'd2);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    check_lanes("t6_restart", 16'd2);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sfp_array.md
Name: sfp_array

Overview:
Multi-column special-function processor. It accumulates a row of signed `bw`-bit partial values per column into signed `psum_bw` accumulators, with saturation and sticky overflow flags. On a read command it emits every column, with optional ReLU. It sits at the bottom of the MAC array, one lane per array column, and generalises the single-lane sfp to `col` lanes with a read handshake and clear-on-read.

Parameters:
- bw, 4, width of each signed input element
- psum_bw, 16, width of each signed accumulator and output element
- col, 8, number of lanes (columns)
- clr_on_rd, 1, 1 = a read restarts accumulation; 0 = a read leaves psum intact

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- in  input  col*bw  packed signed inputs; lane c is in[c*bw +: bw]
- in_valid  input  1  in carries valid data this cycle
- acc  input  1  accumulate enable; sampled together with in_valid
- relu  input  1  output mode sampled on rd: 1 = max(psum,0), 0 = passthrough
- rd  input  1  read command; one-cycle pulse
- clr  input  1  synchronous clear of accumulators, flags and count
- out  output  col*psum_bw  packed signed results; lane c is out[c*psum_bw +: psum_bw]
- out_valid  output  1  one-cycle pulse; out updated this cycle
- sat  output  col  sticky per-lane saturation flag
- acc_cnt  output  16  number of accumulate events since the last clear, read-clear or reset; saturates at 16'hFFFF

Behaviour:
- Reset (async, immediate, no clock needed): psum=0, out=0, out_valid=0, sat=0, acc_cnt=0.
- Accumulate event (acc & in_valid):
  - psum[c] <= SAT(psum[c] + sext(in[c])), visible the next cycle.
  - Sum is computed in psum_bw+1 bits, then clamped to [-2^(psum_bw-1), 2^(psum_bw-1)-1].
  - When clamped, sat[c] <= 1 and stays 1 until clr or reset.
- acc=1 with in_valid=0, or acc=0: psum holds and acc_cnt holds.
- Read (rd=1):
  - Next cycle: out[c] <= relu ? (psum[c]<0 ? 0 : psum[c]) : psum[c], using the pre-update psum; out_valid=1 for exactly that cycle.
  - out holds its value until the next read or reset.
- Read with clr_on_rd=1:
  - psum[c] <= 0, acc_cnt <= 0, sat <= 0.
  - If an accumulate event occurs in the same cycle: psum[c] <= sext(in[c]) and acc_cnt <= 1. That input belongs to the new accumulation.
- Read with clr_on_rd=0: psum is unaffected by the read, and a simultaneous accumulate proceeds normally. out still reflects the pre-update psum.
- Priority: clr > rd > acc.
  - clr=1: psum=0, sat=0, acc_cnt=0 next cycle. Any same-cycle rd is ignored (no out_valid) and any same-cycle accumulate is dropped.
- Back-to-back rd on consecutive cycles: each produces its own out_valid pulse.
  - With clr_on_rd=1 and no input, the second read emits 0.
- Reset asserted mid-accumulation or mid-read: all state clears at once, and a pending out_valid is cancelled.
- Control FSM per array (IDLE, ACCUM, EMIT):
  - IDLE -> ACCUM on the first accumulate event.
  - ACCUM or IDLE -> EMIT on rd.
  - EMIT -> ACCUM if psum is retained or a same-cycle accumulate occurred; otherwise EMIT -> IDLE.
  - clr -> IDLE.
  - out_valid = (state==EMIT).
- Latency: input to psum is 1 cycle; rd to out/out_valid is 1 cycle. Sustained throughput is one accumulate per cycle, including during a read.

Decomposition:
- Package sfp_pkg: psum saturation limits as functions of psum_bw, FSM state encoding (IDLE=2'd0, ACCUM=2'd1, EMIT=2'd2), and the acc_cnt width constant.
- Sub-module sfp_lane: one column's psum register, saturating adder, sat flag and ReLU/output register. Instantiated col times in a generate loop.
- Top level sfp_array: FSM, acc_cnt and clr/rd priority decode.

Test Plan:
- Reset, then all lanes in=3 with acc=in_valid=1 for 10 cycles, then rd with relu=1 -> out every lane = 30; out_valid high exactly 1 cycle; acc_cnt=10 before the read and 0 after.
- Lane 0 in=-8 x10, then rd relu=1 -> out[0]=0; repeat the 10 cycles with rd relu=0 -> out[0]=-80 (16'hFFB0); sat[0]=0.
- With psum_bw=8, lane 0 in=7 x20 -> psum clamps at 127, sat[0]=1 and stays 1 until clr. Then in=-8 x40 -> clamps at -128.
- clr_on_rd=1: psum=30, then rd together with an in=5 accumulate -> out=30 next cycle; following read gives 5; acc_cnt=1 after the read cycle.
- clr, rd and an accumulate in the same cycle -> no out_valid; psum=0, sat=0, acc_cnt=0; out keeps its previous value.
- Assert reset between clock edges mid-accumulation -> out, out_valid, sat and acc_cnt go 0 before the next clk edge; the next accumulation restarts from 0.
